// File: rtl/stream_rr_arbiter5_if.sv
// Stream bundle between five requesters, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface stream_rr_arbiter5_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  val_in1, val_in2, val_in3, val_in4, val_in5;
  logic [DATA_WIDTH-1:0] din1, din2, din3, din4, din5;
  logic                  ready_upward1, ready_upward2, ready_upward3, ready_upward4, ready_upward5;
  logic                  val_out;
  logic [DATA_WIDTH-1:0] dout;
  logic [2:0]            src_id;
  logic                  ready_downward;

  modport slave (
    input  val_in1, val_in2, val_in3, val_in4, val_in5,
    input  din1, din2, din3, din4, din5,
    input  ready_downward,
    output ready_upward1, ready_upward2, ready_upward3, ready_upward4, ready_upward5,
    output val_out, dout, src_id
  );

  modport master (
    output val_in1, val_in2, val_in3, val_in4, val_in5,
    output din1, din2, din3, din4, din5,
    output ready_downward,
    input  ready_upward1, ready_upward2, ready_upward3, ready_upward4, ready_upward5,
    input  val_out, dout, src_id
  );
endinterface

// File: rtl/stream_rr_arbiter5.sv
// Five-to-one round-robin stream merger with a one-entry output register and source tag.
// Optional burst locking (up to MAX_BURST consecutive beats per port) under `ARB_BURST_LOCK_EN.
module stream_rr_arbiter5 #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input logic                clk,
  input logic                resetn,
  stream_rr_arbiter5_if.slave bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..15");
  end

  logic [5:1]            w_req;
  logic                  w_can_accept;
  logic                  w_found;
  logic [2:0]            w_grant;
  logic [3:0]            w_probe;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_sel;

  logic                  r_val_out;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [2:0]            r_src_id;
  logic [2:0]            r_last_ptr;

  assign w_req        = {bus.val_in5, bus.val_in4, bus.val_in3, bus.val_in2, bus.val_in1};
  assign w_can_accept = ~r_val_out | bus.ready_downward;

`ifdef ARB_BURST_LOCK_EN
  logic [3:0] r_burst_cnt;
  logic       r_lock;
  logic       w_lock_hit;
  logic [3:0] w_cnt_next;
  logic       w_lock_next;

  assign w_lock_hit  = r_lock & w_req[r_last_ptr];
  assign w_cnt_next  = (r_lock && (w_grant == r_last_ptr)) ? r_burst_cnt + 4'd1 : 4'd0;
  assign w_lock_next = (int'(w_cnt_next) + 1) < MAX_BURST;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_burst_cnt <= 4'd0;
      r_lock      <= 1'b0;
    end else if (w_xfer) begin
      r_burst_cnt <= w_cnt_next;
      r_lock      <= w_lock_next;
    end else if (r_lock && !w_req[r_last_ptr]) begin
      r_burst_cnt <= 4'd0;
      r_lock      <= 1'b0;
    end
  end
`endif

  // Search starts one past the last grant and wraps 5->1, ending on last_ptr itself.
  always_comb begin
    w_found = 1'b0;
    w_grant = 3'd0;
    w_probe = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      w_probe = 4'(r_last_ptr) + 4'(k);
      if (w_probe > 4'd5) w_probe = w_probe - 4'd5;
      if (!w_found && w_req[w_probe[2:0]]) begin
        w_found = 1'b1;
        w_grant = w_probe[2:0];
      end
    end
`ifdef ARB_BURST_LOCK_EN
    if (w_lock_hit) begin
      w_found = 1'b1;
      w_grant = r_last_ptr;
    end
`endif
  end

  assign w_xfer = w_found & w_can_accept;

  always_comb begin
    w_sel = '0;
    case (w_grant)
      3'd1:    w_sel = bus.din1;
      3'd2:    w_sel = bus.din2;
      3'd3:    w_sel = bus.din3;
      3'd4:    w_sel = bus.din4;
      3'd5:    w_sel = bus.din5;
      default: w_sel = '0;
    endcase
  end

  assign bus.ready_upward1 = w_xfer & (w_grant == 3'd1);
  assign bus.ready_upward2 = w_xfer & (w_grant == 3'd2);
  assign bus.ready_upward3 = w_xfer & (w_grant == 3'd3);
  assign bus.ready_upward4 = w_xfer & (w_grant == 3'd4);
  assign bus.ready_upward5 = w_xfer & (w_grant == 3'd5);

  // A load wins over a drain, so back-to-back beats leave no bubble.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_val_out  <= 1'b0;
      r_dout     <= '0;
      r_src_id   <= 3'd0;
      r_last_ptr <= 3'd5;
    end else if (w_xfer) begin
      r_val_out  <= 1'b1;
      r_dout     <= w_sel;
      r_src_id   <= w_grant;
      r_last_ptr <= w_grant;
    end else if (bus.ready_downward) begin
      r_val_out  <= 1'b0;
    end
  end

  assign bus.val_out = r_val_out;
  assign bus.dout    = r_dout;
  assign bus.src_id  = r_src_id;

endmodule

// File: tb/tb_stream_rr_arbiter5.sv
// Directed bench for stream_rr_arbiter5: grant order, backpressure, reset and burst lock,
// with a scoreboard comparing every beat leaving the output register.
module tb_stream_rr_arbiter5;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  stream_rr_arbiter5_if #(.DATA_WIDTH(32)) bus ();

  stream_rr_arbiter5 #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0]  src;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] pay(int p);
    return 32'h1000_0000 | 32'(p);
  endfunction

  function automatic logic [4:0] rdy();
    return {bus.ready_upward5, bus.ready_upward4, bus.ready_upward3,
            bus.ready_upward2, bus.ready_upward1};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_val(logic [4:0] v);
    bus.val_in1 = v[0];
    bus.val_in2 = v[1];
    bus.val_in3 = v[2];
    bus.val_in4 = v[3];
    bus.val_in5 = v[4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect port p to be granted this cycle, queue its beat, advance one edge.
  task automatic stream(int p);
    #1;
    chk($sformatf("grant_p%0d", p), 32'(rdy()), 32'(5'b1 << (p - 1)));
    sb.push_back(beat_t'{3'(p), pay(p)});
    tick();
  endtask

  always @(negedge clk) begin
    if (resetn && bus.val_out && bus.ready_downward) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=src%0d expected=none", bus.src_id);
      end
      if (sb.size() > 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("sb_src", 32'(bus.src_id), 32'(e.src));
        chk("sb_data", bus.dout, e.data);
        $display("beat src=%0d data=%h exp_src=%0d exp_data=%h", bus.src_id, bus.dout, e.src, e.data);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    set_val(5'b0);
    bus.din1 = pay(1); bus.din2 = pay(2); bus.din3 = pay(3);
    bus.din4 = pay(4); bus.din5 = pay(5);
    bus.ready_downward = 1'b1;
    tick(); tick();
    chk("rst_val_out", 32'(bus.val_out), 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_src_id", 32'(bus.src_id), 32'd0);
    chk("rst_ready", 32'(rdy()), 32'd0);
    resetn = 1'b1;

    // Single beat from port 3
    set_val(5'b00100);
    bus.din3 = 32'hA5A5_0003;
    #1;
    chk("single_ready", 32'(rdy()), 32'b00100);
    sb.push_back(beat_t'{3'd3, 32'hA5A5_0003});
    tick();
    set_val(5'b0);
    bus.din3 = pay(3);
    chk("single_val_out", 32'(bus.val_out), 32'd1);
    chk("single_dout", bus.dout, 32'hA5A5_0003);
    chk("single_src", 32'(bus.src_id), 32'd3);
    tick();
    chk("single_drained", 32'(bus.val_out), 32'd0);

    // Reset to bring priority back to port 1
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
`ifndef ARB_BURST_LOCK_EN
    set_val(5'b11111);
    stream(1); stream(2); stream(3); stream(4); stream(5); stream(1);
    chk("rr_no_bubble", 32'(bus.val_out), 32'd1);
    stream(2);
    set_val(5'b0);
    tick();
`endif

    // Backpressure: port 2 buffered, port 3 waiting
    set_val(5'b00010);
    bus.din2 = 32'hB0B0_0002;
    #1;
    chk("bp_ready2", 32'(rdy()), 32'b00010);
    sb.push_back(beat_t'{3'd2, 32'hB0B0_0002});
    tick();
    set_val(5'b00100);
    bus.din3 = 32'hC0C0_0003;
    bus.ready_downward = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_val_out", 32'(bus.val_out), 32'd1);
      chk("bp_src", 32'(bus.src_id), 32'd2);
      chk("bp_dout", bus.dout, 32'hB0B0_0002);
      chk("bp_ready_low", 32'(rdy()), 32'd0);
      if (i < 2) tick();
    end
    bus.ready_downward = 1'b1;
    #1;
    chk("bp_release_ready3", 32'(rdy()), 32'b00100);
    sb.push_back(beat_t'{3'd3, 32'hC0C0_0003});
    tick();
    set_val(5'b0);
    bus.din2 = pay(2);
    chk("bp_load_val", 32'(bus.val_out), 32'd1);
    chk("bp_load_src", 32'(bus.src_id), 32'd3);
    chk("bp_load_dout", bus.dout, 32'hC0C0_0003);
    bus.din3 = pay(3);
    tick();
    chk("bp_drained", 32'(bus.val_out), 32'd0);

    // Reset mid-operation: buffered beat from port 4 is discarded
    set_val(5'b01001);
    #1;
    chk("mid_ready4", 32'(rdy()), 32'b01000);
    tick();
    chk("mid_loaded", 32'(bus.val_out), 32'd1);
    resetn = 1'b0;
    bus.ready_downward = 1'b0;
    tick();
    chk("mid_rst_val_out", 32'(bus.val_out), 32'd0);
    chk("mid_rst_src", 32'(bus.src_id), 32'd0);
    resetn = 1'b1;
    bus.ready_downward = 1'b1;
`ifdef ARB_BURST_LOCK_EN
    set_val(5'b00011);
    stream(1); stream(1); stream(1); stream(1);
    stream(2); stream(2); stream(2); stream(2);
    stream(1);
`else
    stream(1); stream(4); stream(1); stream(4);
`endif
    set_val(5'b0);
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
